// File: rtl/run_scan_ctrl_pkg.sv
// Shared encodings for the run-scan sequencer and its run-length detector.
package run_scan_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // S1..S4 count consecutive ones, S5..S8 consecutive zeros; S4/S8 are "run seen".
  localparam logic [3:0] D_S0 = 4'd0;
  localparam logic [3:0] D_S1 = 4'd1;
  localparam logic [3:0] D_S2 = 4'd2;
  localparam logic [3:0] D_S3 = 4'd3;
  localparam logic [3:0] D_S4 = 4'd4;
  localparam logic [3:0] D_S5 = 4'd5;
  localparam logic [3:0] D_S6 = 4'd6;
  localparam logic [3:0] D_S7 = 4'd7;
  localparam logic [3:0] D_S8 = 4'd8;

endpackage

// File: rtl/run_scan_ctrl_if.sv
// Word-in / result-out valid-ready bundle of the run-scan sequencer.
interface run_scan_ctrl_if #(
  parameter int W = 8
);
  localparam int CW = $clog2(W + 1);
  localparam int IW = $clog2(W);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_word;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;
  logic          res_hit;
  logic [IW-1:0] res_first;

  modport master (
    output in_valid, in_word, res_ready,
    input  in_ready, res_valid, res_count, res_hit, res_first
  );

  modport slave (
    input  in_valid, in_word, res_ready,
    output in_ready, res_valid, res_count, res_hit, res_first
  );
endinterface

// File: rtl/run_scan_ctrl_detector.sv
// 9-state Moore detector flagging every bit that completes or extends a run of 4 equal bits.
module run_detector
  import run_scan_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic [3:0] state;
  logic [3:0] state_nxt;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = D_S0;
    case (state)
      D_S0:    state_nxt = in ? D_S1 : D_S5;
      D_S1:    state_nxt = in ? D_S2 : D_S5;
      D_S2:    state_nxt = in ? D_S3 : D_S5;
      D_S3:    state_nxt = in ? D_S4 : D_S5;
      D_S4:    state_nxt = in ? D_S4 : D_S5;
      D_S5:    state_nxt = in ? D_S1 : D_S6;
      D_S6:    state_nxt = in ? D_S1 : D_S7;
      D_S7:    state_nxt = in ? D_S1 : D_S8;
      D_S8:    state_nxt = in ? D_S1 : D_S8;
      default: state_nxt = D_S0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= D_S0;
      out   <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= (state_nxt == D_S4) || (state_nxt == D_S8);
    end
  end

endmodule

// File: rtl/run_scan_ctrl.sv
// Serialises a W-bit word into run_detector and returns {count, hit, first index} of run flags.
module run_scan_ctrl
  import run_scan_ctrl_pkg::*;
#(
  parameter int W   = 8,
  parameter int RUN = 4
) (
  input  logic          clk,
  input  logic          reset,
  run_scan_ctrl_if.slave bus
);

  localparam int CW = $clog2(W + 1);
  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(W);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [W-1:0]  word;
  logic [IW-1:0] bit_idx;
  logic [CW-1:0] count;
  logic [IW-1:0] first;
  logic          hit;

  logic          accept;
  logic          det_in;
  logic          det_out;
  logic          sample;
  logic [IW-1:0] flag_idx;

  assign accept   = (state == ST_IDLE) && bus.in_valid;
  assign det_in   = (state == ST_SHIFT) ? word[bit_idx] : 1'b0;
  // det_out lags det_in by one cycle, so a flag seen now belongs to the previous bit.
  assign sample   = ((state == ST_SHIFT) && (bit_idx != '0)) || (state == ST_DRAIN);
  assign flag_idx = (state == ST_DRAIN) ? LAST_IDX : bit_idx - IW'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.in_valid) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_idx == LAST_IDX) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  if (bus.res_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      // NOTE: the word register is reset too; it is one W-bit register, not a memory array.
      word    <= '0;
      bit_idx <= '0;
      count   <= '0;
      first   <= '0;
      hit     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        word    <= bus.in_word;
        bit_idx <= '0;
        count   <= '0;
        first   <= '0;
        hit     <= 1'b0;
      end else begin
        if (state == ST_SHIFT) begin
          bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + IW'(1);
        end
        if (sample && det_out) begin
          if (count != MAX_CNT) count <= count + CW'(1);
          if (!hit) begin
            hit   <= 1'b1;
            first <= flag_idx;
          end
        end
      end
    end
  end

  // Only the 4-bit-run detector exists; other RUN values elaborate without one.
  if (RUN == 4) begin : g_det
    run_detector u_det (
      .clk   (clk),
      .reset (reset | accept),
      .in    (det_in),
      .out   (det_out)
    );
  end else begin : g_no_det
    assign det_out = 1'b0;
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.res_valid = (state == ST_DONE);
  assign bus.res_count = count;
  assign bus.res_hit   = hit;
  assign bus.res_first = first;

endmodule
